// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register and fetch-request stage. Resolves beq/bne/j
// redirects into the next fetch address and buffers a redirect that arrives
// while fetch cannot advance, so it is applied on the next accepted fetch.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             branch_i,
  input  logic             bne_i,
  input  logic             zero_i,
  input  logic             jump_i,
  input  logic [31:0]      br_pc4_i,
  input  logic [31:0]      shifted_offset_i,
  input  logic [25:0]      jump_field_i,
  input  logic             stall_i,
  input  logic             imem_ready_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  // state | meaning
  // BOOT  | first cycle after reset, no fetch request issued
  // RUN   | fetch requests issued every cycle
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;

  logic        advance;
  logic        taken;
  logic        req;
  logic [31:0] br_tgt;
  logic [31:0] req_tgt;

  assign fetch_valid_o = (state_q == RUN);
  assign advance       = fetch_valid_o & imem_ready_i & ~stall_i;
  assign taken         = branch_i & (zero_i ^ bne_i);
  assign req           = jump_i | taken;
  assign br_tgt        = br_pc4_i + shifted_offset_i;
  // Jump has priority when decode flags both; low two bits are never fetchable.
  assign req_tgt       = jump_i ? {br_pc4_i[31:28], jump_field_i, 2'b00}
                                : {br_tgt[31:2], 2'b00};

  // State register and all registered datapath/outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-state: FSM step, next PC selection, pending buffer and redirect count.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    flush_d    = 1'b0;
    cnt_d      = cnt_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (advance) begin
      if (req) begin
        pc_d    = req_tgt;
        flush_d = 1'b1;
      end else if (pend_v_q) begin
        pc_d    = pend_tgt_q;
        flush_d = 1'b1;
      end else begin
        pc_d    = pc_plus4_q;
      end
      pc_plus4_d = pc_d + 32'd4;
      pend_v_d   = 1'b0;
    end else if (req) begin
      // Latest redirect wins if several arrive while fetch is held.
      pend_v_d   = 1'b1;
      pend_tgt_d = req_tgt;
    end

    if (flush_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4_q;
  assign flush_o        = flush_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed scenarios followed by random stimulus,
// all checked against a cycle-level reference model of the fetch stage.
module tb_branch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, branch, bne, zero, jump, stall, ready;
  logic [31:0] br_pc4, offset;
  logic [25:0] field;
  logic [31:0] pc, pc4;
  logic fvalid, flush;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_tgt;
  logic        m_flush;
  int          m_cnt;
  logic        m_running;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .branch_i(branch), .bne_i(bne), .zero_i(zero),
    .jump_i(jump), .br_pc4_i(br_pc4), .shifted_offset_i(offset),
    .jump_field_i(field), .stall_i(stall), .imem_ready_i(ready),
    .pc_o(pc), .pc_plus4_o(pc4), .fetch_valid_o(fvalid), .flush_o(flush),
    .redirect_cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pend_v = 1'b0; m_pend_tgt = '0;
    m_flush = 1'b0; m_cnt = 0; m_running = 1'b0;
  endtask

  // One clock edge of the fetch stage, evaluated on the inputs held at that edge.
  task automatic model_edge();
    logic adv, req;
    logic [31:0] tgt;
    logic redirected;
    if (rst) begin
      model_reset();
    end else begin
      adv = m_running && ready && !stall;
      req = jump || (branch && (zero != bne));
      if (jump) tgt = (br_pc4 & 32'hF000_0000) | ({6'd0, field} * 32'd4);
      else      tgt = (br_pc4 + offset) & 32'hFFFF_FFFC;
      redirected = 1'b0;
      if (adv) begin
        if (req)           begin m_pc = tgt;        redirected = 1'b1; end
        else if (m_pend_v) begin m_pc = m_pend_tgt; redirected = 1'b1; end
        else               m_pc = m_pc + 32'd4;
        m_pend_v = 1'b0;
      end else if (req) begin
        m_pend_v = 1'b1;
        m_pend_tgt = tgt;
      end
      if (redirected && m_cnt < 65535) m_cnt++;
      m_flush = redirected;
      m_running = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    branch = 0; bne = 0; zero = 0; jump = 0; stall = 0; ready = 1; rst = 0;
    br_pc4 = '0; offset = '0; field = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc4, m_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, fvalid}, {31'd0, m_running});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
    chk({tag, ".cnt"}, {16'd0, cnt}, m_cnt[31:0]);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 1; tick("rst");
    chk("rst_pc_const", pc, 32'h0040_0000);
    // boot cycle then sequential fetch
    tick("boot");
    chk("boot_valid", {31'd0, fvalid}, 32'd1);
    chk("boot_pc", pc, 32'h0040_0000);
    tick("seq1");
    chk("seq1_pc", pc, 32'h0040_0004);
    tick("seq2");
    chk("seq2_pc", pc, 32'h0040_0008);

    // beq taken
    branch = 1; zero = 1; br_pc4 = 32'h10; offset = 32'hFFFF_FFF8;
    tick("beq");
    chk("beq_pc", pc, 32'h0000_0008);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_cnt", {16'd0, cnt}, 32'd1);
    tick("beq_after");
    chk("beq_flush_drop", {31'd0, flush}, 32'd0);
    // bne not taken with zero=1
    branch = 1; bne = 1; zero = 1; br_pc4 = 32'h10; offset = 32'hFFFF_FFF8;
    tick("bne_nt");
    chk("bne_nt_pc", pc, 32'h0000_0010);
    chk("bne_nt_flush", {31'd0, flush}, 32'd0);

    // jump, then jump + branch together
    jump = 1; br_pc4 = 32'h1000_0004; field = 26'h000_0100;
    tick("j");
    chk("j_pc", pc, 32'h1000_0400);
    jump = 1; branch = 1; zero = 1; br_pc4 = 32'h1000_0004; field = 26'h000_0100;
    offset = 32'h40;
    tick("jb");
    chk("jb_pc", pc, 32'h1000_0400);

    // redirect while memory not ready, overwritten during the wait
    ready = 0; jump = 1; br_pc4 = 32'h2000_0000; field = 26'h000_0040;
    tick("wait1");
    ready = 0; branch = 1; zero = 1; br_pc4 = 32'h0000_1000; offset = 32'h0000_0100;
    tick("wait2");
    ready = 0;
    tick("wait3");
    chk("wait_hold", pc, 32'h1000_0400);
    tick("wait_apply");
    chk("wait_pc", pc, 32'h0000_1100);
    chk("wait_flush", {31'd0, flush}, 32'd1);

    // wrap from top of address space
    jump = 1; br_pc4 = 32'hF000_0000; field = 26'h3FF_FFFF;
    tick("top");
    chk("top_pc", pc, 32'hFFFF_FFFC);
    tick("wrap");
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_pc4", pc4, 32'h0000_0004);

    // reset discards a pending redirect and a same-cycle request
    ready = 0; jump = 1; br_pc4 = 32'h3000_0000; field = 26'h000_0010;
    tick("pend");
    rst = 1; jump = 1; br_pc4 = 32'h3000_0000; field = 26'h000_0020;
    tick("rst_pend");
    chk("rst_pend_pc", pc, RESET_PC);
    chk("rst_pend_flush", {31'd0, flush}, 32'd0);
    tick("rst_boot");
    tick("rst_run");
    chk("rst_run_pc", pc, RESET_PC + 32'd4);
    chk("rst_run_flush", {31'd0, flush}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 249) == 0);
      branch = ($urandom_range(0, 3) == 0);
      bne    = $urandom_range(0, 1);
      zero   = $urandom_range(0, 1);
      jump   = ($urandom_range(0, 5) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      br_pc4 = $urandom;
      offset = $urandom;
      field  = 26'($urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
